// File: rtl/wb_select_buffer_pkg.sv
// Shared definitions for the writeback-select stage: FSM states and fixed widths.
package wb_select_buffer_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } wb_state_e;

   localparam int unsigned ZERO_REG   = 0;
   localparam int unsigned WB_COUNT_W = 16;

endpackage

// File: rtl/wb_select_buffer_src_mux.sv
// Combinational N:1 writeback source select with out-of-range detection.
module wb_src_mux #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 2,
   parameter int SEL_W   = 1
) (
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src,
   output logic [WIDTH-1:0]         data,
   output logic                     oor
);

   // Pick source 'sel'; a select matching no source yields zero data and raises oor.
   always_comb begin
      data = '0;
      oor  = 1'b1;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            data = src[k*WIDTH +: WIDTH];
            oor  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_select_buffer.sv
// Writeback-select stage: N:1 source mux feeding a 2-entry skid buffer with
// valid/ready handshake, flush, sticky select-error flag and pop counter.
module wb_select_buffer
   import wb_select_buffer_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 2,
   parameter int SEL_W   = 1,
   parameter int RD_W    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [NUM_SRC*WIDTH-1:0] in_src,
   input  logic [RD_W-1:0]          in_rd,
   input  logic                     in_we,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [RD_W-1:0]          out_rd,
   output logic                     out_we,
   output logic                     sel_err,
   output logic [WB_COUNT_W-1:0]    wb_count
);

   wb_state_e               state_q, state_nx;

   logic [WIDTH-1:0]        head_data_q, tail_data_q;
   logic [RD_W-1:0]         head_rd_q,   tail_rd_q;
   logic                    head_we_q,   tail_we_q;

   logic [WIDTH-1:0]        mux_data;
   logic                    mux_oor;
   logic [WIDTH-1:0]        new_data;
   logic                    new_we;

   logic                    accept, pop;
   logic                    load_head, load_tail, shift_tail;
   logic                    sel_err_q;
   logic [WB_COUNT_W-1:0]   count_q;

   wb_src_mux #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_src_mux (
      .sel  (in_sel),
      .src  (in_src),
      .data (mux_data),
      .oor  (mux_oor)
   );

   // Handshake and entry formation; ready comes only from registered state and rst.
   always_comb begin
      in_ready  = ~rst & (state_q != ST_FULL);
      out_valid = (state_q != ST_EMPTY);
      accept    = in_valid & in_ready;
      pop       = out_valid & out_ready;
      new_data  = mux_oor ? '0 : mux_data;
      new_we    = in_we & ~mux_oor & (in_rd != RD_W'(ZERO_REG));
      out_data  = head_data_q;
      out_rd    = head_rd_q;
      out_we    = out_valid & head_we_q;
      sel_err   = sel_err_q;
      wb_count  = count_q;
   end

   // Next-state and entry-register load controls; flush overrides everything.
   always_comb begin
      state_nx   = state_q;
      load_head  = 1'b0;
      load_tail  = 1'b0;
      shift_tail = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_nx  = ST_ONE;
               load_head = 1'b1;
            end
         end
         ST_ONE: begin
            unique case ({accept, pop})
               2'b10: begin
                  state_nx  = ST_FULL;
                  load_tail = 1'b1;
               end
               2'b01: state_nx = ST_EMPTY;
               2'b11: begin
                  state_nx  = ST_ONE;
                  load_head = 1'b1;
               end
               default: state_nx = ST_ONE;
            endcase
         end
         ST_FULL: begin
            if (pop) begin
               state_nx   = ST_ONE;
               shift_tail = 1'b1;
            end
         end
         default: state_nx = ST_EMPTY;
      endcase
      if (flush) begin
         state_nx   = ST_EMPTY;
         load_head  = 1'b0;
         load_tail  = 1'b0;
         shift_tail = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_nx;
   end

   // Head/tail entry registers; head refills either from input or from the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_data_q <= '0;
         head_rd_q   <= '0;
         head_we_q   <= 1'b0;
         tail_data_q <= '0;
         tail_rd_q   <= '0;
         tail_we_q   <= 1'b0;
      end else begin
         if (load_head) begin
            head_data_q <= new_data;
            head_rd_q   <= in_rd;
            head_we_q   <= new_we;
         end else if (shift_tail) begin
            head_data_q <= tail_data_q;
            head_rd_q   <= tail_rd_q;
            head_we_q   <= tail_we_q;
         end
         if (load_tail) begin
            tail_data_q <= new_data;
            tail_rd_q   <= in_rd;
            tail_we_q   <= new_we;
         end
      end
   end

   // Sticky select error (only for entries actually kept) and wrapping pop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
         count_q   <= '0;
      end else begin
         if (accept & mux_oor & ~flush) sel_err_q <= 1'b1;
         if (pop)                       count_q   <= count_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_select_buffer.sv
// Bench for wb_select_buffer (3 sources): queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_wb_select_buffer;

   localparam int WIDTH   = 32;
   localparam int NUM_SRC = 3;
   localparam int SEL_W   = 2;
   localparam int RD_W    = 5;

   logic                     clk = 1'b0;
   logic                     rst, flush, in_valid, in_ready, in_we;
   logic [SEL_W-1:0]         in_sel;
   logic [WIDTH-1:0]         src0, src1, src2;
   logic [NUM_SRC*WIDTH-1:0] in_src;
   logic [RD_W-1:0]          in_rd, out_rd;
   logic                     out_valid, out_ready, out_we, sel_err;
   logic [WIDTH-1:0]         out_data;
   logic [15:0]              wb_count;

   assign in_src = {src2, src1, src0};

   wb_select_buffer #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W),
      .RD_W    (RD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_src    (in_src),
      .in_rd     (in_rd),
      .in_we     (in_we),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_we    (out_we),
      .sel_err   (sel_err),
      .wb_count  (wb_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries.
   typedef struct {
      logic [WIDTH-1:0] data;
      logic [RD_W-1:0]  rd;
      logic             we;
   } entry_t;

   entry_t      m_q[$];
   logic [15:0] m_count = '0;
   logic        m_err   = 1'b0;

   always @(posedge clk) begin
      bit     acc, pp;
      entry_t e;
      if (rst) begin
         m_q.delete();
         m_count = '0;
         m_err   = 1'b0;
      end else begin
         acc = in_valid && (m_q.size() < 2);
         pp  = (m_q.size() > 0) && out_ready;
         if (pp) begin
            void'(m_q.pop_front());
            m_count = m_count + 16'd1;
         end
         if (flush) m_q.delete();
         else if (acc) begin
            case (int'(in_sel))
               0:       e.data = src0;
               1:       e.data = src1;
               2:       e.data = src2;
               default: e.data = '0;
            endcase
            e.rd = in_rd;
            e.we = in_we && (int'(in_sel) < NUM_SRC) && (in_rd != 0);
            if (int'(in_sel) >= NUM_SRC) m_err = 1'b1;
            m_q.push_back(e);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         m_q.delete();
         m_count = '0;
         m_err   = 1'b0;
      end
      check("in_ready",  32'(in_ready),  32'(!rst && m_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         check("out_data", out_data,       m_q[0].data);
         check("out_rd",   32'(out_rd),    32'(m_q[0].rd));
         check("out_we",   32'(out_we),    32'(m_q[0].we));
      end else begin
         check("out_we_idle", 32'(out_we), 32'(0));
      end
      check("sel_err",  32'(sel_err),  32'(m_err));
      check("wb_count", 32'(wb_count), 32'(m_count));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [1:0] sel, input logic [31:0] d, input logic [4:0] rd);
      in_valid = 1'b1;
      in_sel   = sel;
      src0     = d;
      src1     = d;
      src2     = d;
      in_rd    = rd;
      in_we    = 1'b1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_sel = '0;
      src0 = '0; src1 = '0; src2 = '0; in_rd = '0; out_ready = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_count", 32'(wb_count), 32'd0);

      // Select source 1 then source 0
      in_valid = 1'b1; in_sel = 2'd1; src0 = 32'd432; src1 = 32'd984; src2 = 32'd77;
      in_rd = 5'd3; in_we = 1'b1; out_ready = 1'b1;
      tick();
      check("sel1_data", out_data, 32'd984);
      check("sel1_we", 32'(out_we), 32'd1);
      check("sel1_rd", 32'(out_rd), 32'd3);
      in_sel = 2'd0;
      tick();
      check("sel0_data", out_data, 32'd432);
      check("sel0_count", 32'(wb_count), 32'd1);
      in_valid = 1'b0;
      tick();
      check("drain_count", 32'(wb_count), 32'd2);
      check("drain_valid", 32'(out_valid), 32'd0);

      // Back-pressure: fill, hold, then drain in order
      out_ready = 1'b0;
      push(2'd0, 32'd342, 5'd4);
      tick();
      check("bp_head", out_data, 32'd342);
      src0 = 32'd532;
      tick();
      check("bp_full_ready", 32'(in_ready), 32'd0);
      check("bp_hold", out_data, 32'd342);
      in_valid = 1'b0;
      tick();
      check("bp_hold2", out_data, 32'd342);
      out_ready = 1'b1;
      tick();
      check("bp_second", out_data, 32'd532);
      check("bp_count1", 32'(wb_count), 32'd3);
      tick();
      check("bp_count2", 32'(wb_count), 32'd4);
      check("bp_empty", 32'(out_valid), 32'd0);

      // Zero destination register: data passes, write suppressed
      push(2'd1, 32'd984, 5'd0);
      tick();
      check("rd0_data", out_data, 32'd984);
      check("rd0_we", 32'(out_we), 32'd0);
      in_valid = 1'b0;
      tick();

      // Out-of-range select
      push(2'd3, 32'd555, 5'd7);
      tick();
      check("oor_data", out_data, 32'd0);
      check("oor_we", 32'(out_we), 32'd0);
      check("oor_err", 32'(sel_err), 32'd1);
      in_valid = 1'b0; in_sel = 2'd0;
      repeat (3) tick();
      check("oor_sticky", 32'(sel_err), 32'd1);

      // Flush while FULL: incoming entry dropped, popped entry still counted
      out_ready = 1'b0;
      push(2'd2, 32'd11, 5'd1);
      tick();
      src2 = 32'd22;
      tick();
      check("fl_full", 32'(in_ready), 32'd0);
      src2 = 32'd33; flush = 1'b1; out_ready = 1'b1;
      tick();
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_ready", 32'(in_ready), 32'd1);
      check("fl_count", 32'(wb_count), 32'd7);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check("fl_nocap", 32'(out_valid), 32'd0);
      check("fl_err_kept", 32'(sel_err), 32'd1);

      // Reset mid-run while FULL
      out_ready = 1'b0;
      push(2'd1, 32'd5, 5'd9);
      tick();
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_ready", 32'(in_ready), 32'd0);
      check("mr_data", out_data, 32'd0);
      check("mr_rd", 32'(out_rd), 32'd0);
      check("mr_we", 32'(out_we), 32'd0);
      check("mr_err", 32'(sel_err), 32'd0);
      check("mr_count", 32'(wb_count), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("mr_ready_after", 32'(in_ready), 32'd1);

      // Counter wrap: stream at full rate to 0xFFFF, then one more pop
      push(2'd0, 32'd1, 5'd2);
      out_ready = 1'b1;
      repeat (65536) tick();
      check("wrap_ffff", 32'(wb_count), 32'h0000_FFFF);
      in_valid = 1'b0;
      tick();
      check("wrap_zero", 32'(wb_count), 32'd0);
      check("wrap_empty", 32'(out_valid), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
